spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- Sits directly downstream of spi_slave and consumes its received-byte stream.
- Parses each chip-select frame as a command byte followed by data bytes, then issues register writes or reads on a simple internal register port.
- On reads it supplies the next MISO byte back to spi_slave on spi_byte_data_o, which connects to spi_slave.spi_byte_data_i.
- Target use is the design's control/status register file.

Parameters:
- ADDR_WIDTH, 7, register address width; must be 1..7; address is taken from cmd[ADDR_WIDTH-1:0].
- DATA_BYTES, 4, bytes per register word; word width is 8*DATA_BYTES.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset
- spi_cs_n_i  in  1  raw SPI chip select, active-low, asynchronous to clk_i
- spi_byte_vld_i  in  1  one-cycle pulse per received byte (from spi_slave.spi_byte_vld_o)
- spi_byte_data_i  in  8  received byte (from spi_slave.spi_byte_data_o)
- spi_byte_data_o  out  8  next byte to transmit (to spi_slave.spi_byte_data_i)
- reg_wr_en_o  out  1  one-cycle write strobe
- reg_rd_en_o  out  1  one-cycle read strobe
- reg_addr_o  out  ADDR_WIDTH  register address for the write or read strobe
- reg_wr_data_o  out  8*DATA_BYTES  write data, valid with reg_wr_en_o
- reg_rd_data_i  in  8*DATA_BYTES  read data, valid exactly 1 cycle after reg_rd_en_o

Behaviour:
- Clocking/reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; byte counter 0.
- spi_cs_n_i passes through a 2-flop synchronizer. "Frame active" means the synchronized cs_n is 0.
- Whenever synchronized cs_n is 1:
  - state forces to IDLE; byte counter clears;
  - any partially assembled write word is discarded (no strobe);
  - spi_byte_data_o returns to 0x00.
  - This takes priority over a same-cycle spi_byte_vld_i, which is ignored.
- Command byte (first valid byte of a frame):
  - bit7 = 1 means read, 0 means write.
  - Address = cmd[ADDR_WIDTH-1:0]; bits [6:ADDR_WIDTH] are ignored.
- States:
  - IDLE: on vld with a write cmd, latch addr and go to WR_DATA. On vld with a read cmd, latch addr and go to RD_FETCH.
  - WR_DATA: each vld shifts the byte into the word MSB-first and increments the byte counter.
    - When DATA_BYTES bytes have been collected: on the next clock, reg_wr_en_o=1 for exactly one cycle, with reg_addr_o = current addr and reg_wr_data_o = assembled word.
    - Then addr increments and the counter clears; state stays WR_DATA (burst).
  - RD_FETCH: reg_rd_en_o=1 for exactly one cycle with reg_addr_o = addr; go to RD_LOAD.
  - RD_LOAD: capture reg_rd_data_i into the TX shift register; spi_byte_data_o = MS byte; go to RD_DATA.
  - RD_DATA: each vld increments the byte counter and drives the next byte onto spi_byte_data_o on the following clock.
    - After the DATA_BYTES-th vld: addr increments, counter clears, go to RD_FETCH (burst read).
    - MOSI content during reads is ignored.
- Latency:
  - Write strobe occurs 1 cycle after the final data byte's vld.
  - First read byte appears on spi_byte_data_o 3 cycles after the command byte's vld.
  - The next byte appears 1 cycle after each vld.
  - spi_slave must sample spi_byte_data_o no earlier than 4 clocks after a byte boundary. The SCLK period is ≥ 6 clk_i, so this holds.
- During IDLE and WR_DATA, spi_byte_data_o = 0x00.
- Address wraps modulo 2^ADDR_WIDTH (0x7F+1 → 0x00).
- Strobes never overlap; reg_wr_en_o and reg_rd_en_o are never high together.
- Asynchronous reset mid-frame: all state clears immediately. Bytes received after reset release, while the frame is still active, are parsed as a new command.

Test Plan:
- Write: frame 0x05,0xDE,0xAD,0xBE,0xEF → single reg_wr_en_o pulse, addr 0x05, data 0xDEADBEEF; no reg_rd_en_o.
- Burst write wrap: frame 0x7F + 8 bytes 0x11..0x88 → two pulses: addr 0x7F data 0x11223344, then addr 0x00 data 0x55667788.
- Read: frame 0x83 + 4 dummy bytes, model returns 0x12345678 at addr 3 → rd pulse addr 0x03; MISO bytes 0x12,0x34,0x56,0x78; second rd pulse at addr 0x04 after the 4th byte.
- Abort: frame 0x01,0xAA,0xBB then cs_n high → no write strobe; next frame 0x02,0x01,0x02,0x03,0x04 writes addr 0x02 data 0x01020304.
- Collision: a vld pulse in the same cycle synchronized cs_n goes high → byte ignored, state IDLE.
- Reset: assert rst_n_i low mid-read → all outputs 0x00/0 immediately; the following frame 0x10 + 4 bytes writes addr 0x10 correctly.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
// Turns the byte stream received by spi_slave into accesses on a simple
// register port. Each chip-select frame starts with a command byte and is
// followed by data bytes:
//   cmd[7]            1 = read, 0 = write
//   cmd[ADDR_WIDTH-1:0]  start address (bursts auto-increment and wrap)
// Writes collect DATA_BYTES bytes MSB-first and then pulse reg_wr_en_o.
// Reads pulse reg_rd_en_o, load the returned word, and present it one byte at
// a time on spi_byte_data_o for spi_slave to shift out.
//
// Ports:
//   clk_i, rst_n_i     system clock, asynchronous active-low reset
//   spi_cs_n_i         raw SPI chip select (asynchronous, synchronized here)
//   spi_byte_vld_i     one-cycle pulse per received byte
//   spi_byte_data_i    received byte
//   spi_byte_data_o    next byte to transmit (0x00 outside of read data)
//   reg_wr_en_o        one-cycle write strobe
//   reg_rd_en_o        one-cycle read strobe
//   reg_addr_o         address qualifying either strobe
//   reg_wr_data_o      write data, valid with reg_wr_en_o
//   reg_rd_data_i      read data, valid the cycle after reg_rd_en_o
module spi_reg_bridge #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    spi_cs_n_i,
  input  logic                    spi_byte_vld_i,
  input  logic [7:0]              spi_byte_data_i,
  output logic [7:0]              spi_byte_data_o,
  output logic                    reg_wr_en_o,
  output logic                    reg_rd_en_o,
  output logic [ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [8*DATA_BYTES-1:0] reg_wr_data_o,
  input  logic [8*DATA_BYTES-1:0] reg_rd_data_i
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_RD_FETCH = 3'd2,
    ST_RD_LOAD  = 3'd3,
    ST_RD_DATA  = 3'd4
  } state_t;

  state_t          state_r;
  logic            cs_meta_r;
  logic            cs_sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [W-1:0]    word_r;
  logic [W-1:0]    tx_r;
  logic [W-1:0]    word_next_s;
  logic [ADDR_WIDTH-1:0] addr_inc_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_s;

  // Next write word (new byte shifted in at the LS end) and address helpers.
  always_comb begin
    word_next_s = (word_r << 8) | W'(spi_byte_data_i);
    addr_inc_s  = addr_r + ADDR_WIDTH'(1);
    cmd_addr_s  = spi_byte_data_i[ADDR_WIDTH-1:0];
  end

  // Chip-select synchronizer, frame parser FSM and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // Synchronizer resets to the idle (deasserted) level of cs_n.
      cs_meta_r       <= 1'b1;
      cs_sync_r       <= 1'b1;
      state_r         <= ST_IDLE;
      cnt_r           <= '0;
      addr_r          <= '0;
      word_r          <= '0;
      tx_r            <= '0;
      spi_byte_data_o <= 8'h00;
      reg_wr_en_o     <= 1'b0;
      reg_rd_en_o     <= 1'b0;
      reg_addr_o      <= '0;
      reg_wr_data_o   <= '0;
    end else begin
      cs_meta_r   <= spi_cs_n_i;
      cs_sync_r   <= cs_meta_r;
      reg_wr_en_o <= 1'b0;
      reg_rd_en_o <= 1'b0;

      if (cs_sync_r) begin
        // Frame inactive: drop everything, including a same-cycle byte.
        state_r         <= ST_IDLE;
        cnt_r           <= '0;
        word_r          <= '0;
        tx_r            <= '0;
        spi_byte_data_o <= 8'h00;
      end else begin
        case (state_r)
          ST_IDLE: begin
            spi_byte_data_o <= 8'h00;
            cnt_r           <= '0;
            if (spi_byte_vld_i) begin
              addr_r <= cmd_addr_s;
              if (spi_byte_data_i[7]) begin
                // Strobe is raised on entry so it is high during RD_FETCH.
                state_r     <= ST_RD_FETCH;
                reg_rd_en_o <= 1'b1;
                reg_addr_o  <= cmd_addr_s;
              end else begin
                state_r <= ST_WR_DATA;
                word_r  <= '0;
              end
            end
          end

          ST_WR_DATA: begin
            spi_byte_data_o <= 8'h00;
            if (spi_byte_vld_i) begin
              if (cnt_r == LAST_CNT) begin
                reg_wr_en_o   <= 1'b1;
                reg_addr_o    <= addr_r;
                reg_wr_data_o <= word_next_s;
                addr_r        <= addr_inc_s;
                cnt_r         <= '0;
                word_r        <= '0;
              end else begin
                word_r <= word_next_s;
                cnt_r  <= cnt_r + CNT_W'(1);
              end
            end
          end

          ST_RD_FETCH: begin
            state_r <= ST_RD_LOAD;
          end

          ST_RD_LOAD: begin
            // Read data is valid now, one cycle after the strobe.
            spi_byte_data_o <= reg_rd_data_i[W-1 -: 8];
            tx_r            <= reg_rd_data_i << 8;
            cnt_r           <= '0;
            state_r         <= ST_RD_DATA;
          end

          ST_RD_DATA: begin
            if (spi_byte_vld_i) begin
              spi_byte_data_o <= tx_r[W-1 -: 8];
              tx_r            <= tx_r << 8;
              if (cnt_r == LAST_CNT) begin
                cnt_r       <= '0;
                addr_r      <= addr_inc_s;
                state_r     <= ST_RD_FETCH;
                reg_rd_en_o <= 1'b1;
                reg_addr_o  <= addr_inc_s;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end

          default: begin
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            spi_byte_data_o <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule
